// File: rtl/tri_skid_buf.sv
// Registered valid/ready skid buffer for gate-stage vectors. Vectors are [0:WIDTH-1], bit 0 is the MSB.
// Optional parity storage and checking is enabled by defining TRI_SKID_PARITY_EN.
module tri_skid_buf #(
    parameter int WIDTH    = 1,
    parameter int DATA_INV = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [0:WIDTH-1] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [0:WIDTH-1] out_data,
    input  logic             out_ready,
`ifdef TRI_SKID_PARITY_EN
    output logic             par_err,
`endif
    output logic [1:0]       occupancy
);

    function automatic logic [0:WIDTH-1] cap_f(input logic [0:WIDTH-1] x);
        if (DATA_INV != 0) begin
            cap_f = ~x;
        end else begin
            cap_f = x;
        end
    endfunction

    function automatic logic even_par_f(input logic [0:WIDTH-1] x);
        even_par_f = ^x;
    endfunction

    logic             r_main_v;
    logic             r_skid_v;
    logic [0:WIDTH-1] r_main_d;
    logic [0:WIDTH-1] r_skid_d;
    logic             r_in_ready;
    logic [1:0]       r_occ;

    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_main_v_nxt;
    logic             w_skid_v_nxt;
    logic             w_load_main_in;
    logic             w_load_main_skid;
    logic             w_load_skid;
    logic [0:WIDTH-1] w_cap_d;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_main_v & out_ready;
    assign w_cap_d    = cap_f(in_data);

    // Next-state and load-enable decode over the {main_v, skid_v} state.
    always_comb begin
        w_main_v_nxt     = r_main_v;
        w_skid_v_nxt     = r_skid_v;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            // Flush drops everything, including a same-cycle accept.
            w_main_v_nxt = 1'b0;
            w_skid_v_nxt = 1'b0;
        end else begin
            case ({r_main_v, r_skid_v})
                2'b00: begin
                    if (w_in_fire) begin
                        w_main_v_nxt   = 1'b1;
                        w_load_main_in = 1'b1;
                    end else begin
                        w_main_v_nxt = 1'b0;
                    end
                end
                2'b10: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_main_in = 1'b1;
                    end else if (w_in_fire) begin
                        w_skid_v_nxt = 1'b1;
                        w_load_skid  = 1'b1;
                    end else if (w_out_fire) begin
                        w_main_v_nxt = 1'b0;
                    end else begin
                        w_main_v_nxt = 1'b1;
                    end
                end
                2'b11: begin
                    if (w_out_fire) begin
                        w_skid_v_nxt     = 1'b0;
                        w_load_main_skid = 1'b1;
                    end else begin
                        w_skid_v_nxt = 1'b1;
                    end
                end
                default: begin
                    // Unreachable skid-only state: recover to empty.
                    w_main_v_nxt = 1'b0;
                    w_skid_v_nxt = 1'b0;
                end
            endcase
        end
    end

    // Control state plus registered in_ready and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_v   <= 1'b0;
            r_skid_v   <= 1'b0;
            r_in_ready <= 1'b1;
            r_occ      <= 2'd0;
        end else begin
            r_main_v   <= w_main_v_nxt;
            r_skid_v   <= w_skid_v_nxt;
            r_in_ready <= ~w_skid_v_nxt;
            r_occ      <= {1'b0, w_main_v_nxt} + {1'b0, w_skid_v_nxt};
        end
    end

    // Data registers; flush leaves their contents untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_d <= '0;
            r_skid_d <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_d <= w_cap_d;
            end else if (w_load_main_skid) begin
                r_main_d <= r_skid_d;
            end else begin
                r_main_d <= r_main_d;
            end
            if (w_load_skid) begin
                r_skid_d <= w_cap_d;
            end else begin
                r_skid_d <= r_skid_d;
            end
        end
    end

`ifdef TRI_SKID_PARITY_EN
    logic r_main_p;
    logic r_skid_p;
    logic r_par_err;

    // Parity bits travel with their data words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_p <= 1'b0;
            r_skid_p <= 1'b0;
        end else begin
            if (w_load_main_in) begin
                r_main_p <= even_par_f(w_cap_d);
            end else if (w_load_main_skid) begin
                r_main_p <= r_skid_p;
            end else begin
                r_main_p <= r_main_p;
            end
            if (w_load_skid) begin
                r_skid_p <= even_par_f(w_cap_d);
            end else begin
                r_skid_p <= r_skid_p;
            end
        end
    end

    // Sticky parity error; only reset clears it, flush does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_err <= 1'b0;
        end else if (r_main_v && (even_par_f(r_main_d) != r_main_p)) begin
            r_par_err <= 1'b1;
        end else begin
            r_par_err <= r_par_err;
        end
    end

    assign par_err = r_par_err;
`endif

    assign out_valid = r_main_v;
    assign out_data  = r_main_d;
    assign in_ready  = r_in_ready;
    assign occupancy = r_occ;

endmodule

// File: tb/tb_tri_skid_buf.sv
// Directed self-checking bench for tri_skid_buf: an 8-bit plain instance and a 3-bit inverting instance.
module tb_tri_skid_buf;

    logic       clk;
    logic       rst_n;

    logic       a_flush, a_in_valid, a_out_ready;
    logic [0:7] a_in_data;
    logic       a_in_ready, a_out_valid;
    logic [0:7] a_out_data;
    logic [1:0] a_occ;

    logic       b_flush, b_in_valid, b_out_ready;
    logic [0:2] b_in_data;
    logic       b_in_ready, b_out_valid;
    logic [0:2] b_out_data;
    logic [1:0] b_occ;

`ifdef TRI_SKID_PARITY_EN
    logic       a_par_err;
    logic       b_par_err;
`endif

    int errors = 0;
    int checks = 0;

    tri_skid_buf #(.WIDTH(8), .DATA_INV(0)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(a_flush),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
`ifdef TRI_SKID_PARITY_EN
        .par_err(a_par_err),
`endif
        .occupancy(a_occ)
    );

    tri_skid_buf #(.WIDTH(3), .DATA_INV(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
`ifdef TRI_SKID_PARITY_EN
        .par_err(b_par_err),
`endif
        .occupancy(b_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_flush = 1'($urandom); a_in_valid = 1'($urandom); a_out_ready = 1'($urandom);
            a_in_data = 8'($urandom);
            b_in_valid = 1'($urandom); b_in_data = 3'($urandom);
            step();
            checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
            checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); end
            checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", a_occ); end
            checks++; if (a_out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", a_out_data); end
            checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_out_valid: got %b expected 0", b_out_valid); end
        end
        a_flush = 1'b0; a_in_valid = 1'b1; a_in_data = 8'hA5; a_out_ready = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 3'b000; b_out_ready = 1'b0;
        rst_n = 1'b1;
        step();
        a_in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL first_out_valid: got %b expected 1", a_out_valid); end
        checks++; if (a_out_data !== 8'hA5) begin errors++; $display("FAIL first_out_data: got %h expected a5", a_out_data); end
        checks++; if (a_out_data[0] !== 1'b1) begin errors++; $display("FAIL first_msb_bit0: got %b expected 1", a_out_data[0]); end
        a_out_ready = 1'b1;
        step();
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL first_drain_occ: got %0d expected 0", a_occ); end
    endtask

    task automatic test_streaming();
        logic [0:7] exp_d;
        a_out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            a_in_valid = 1'b1; a_in_data = 8'(i);
            step();
            exp_d = 8'(i);
            checks++; if (a_out_data !== exp_d || a_out_valid !== 1'b1) begin errors++; $display("FAIL stream_data[%0d]: got %h/%b expected %h/1", i, a_out_data, a_out_valid, exp_d); end
            checks++; if (a_occ !== 2'd1 || a_in_ready !== 1'b1) begin errors++; $display("FAIL stream_occ[%0d]: got occ=%0d rdy=%b expected occ=1 rdy=1", i, a_occ, a_in_ready); end
        end
        a_in_valid = 1'b0;
        step();
        checks++; if (a_occ !== 2'd0 || a_out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got occ=%0d v=%b expected 0/0", a_occ, a_out_valid); end
    endtask

    task automatic test_back_pressure();
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'h11;
        step();
        checks++; if (a_occ !== 2'd1 || a_in_ready !== 1'b1 || a_out_data !== 8'h11) begin errors++; $display("FAIL bp_one: got occ=%0d rdy=%b d=%h expected 1/1/11", a_occ, a_in_ready, a_out_data); end
        a_in_data = 8'h22;
        step();
        checks++; if (a_occ !== 2'd2 || a_in_ready !== 1'b0 || a_out_data !== 8'h11) begin errors++; $display("FAIL bp_full: got occ=%0d rdy=%b d=%h expected 2/0/11", a_occ, a_in_ready, a_out_data); end
        a_in_data = 8'h33;
        step();
        checks++; if (a_occ !== 2'd2 || a_in_ready !== 1'b0 || a_out_data !== 8'h11) begin errors++; $display("FAIL bp_hold: got occ=%0d rdy=%b d=%h expected 2/0/11", a_occ, a_in_ready, a_out_data); end
        a_out_ready = 1'b1;
        step();
        checks++; if (a_occ !== 2'd1 || a_in_ready !== 1'b1 || a_out_data !== 8'h22) begin errors++; $display("FAIL bp_skid_move: got occ=%0d rdy=%b d=%h expected 1/1/22", a_occ, a_in_ready, a_out_data); end
        step();
        a_in_valid = 1'b0;
        checks++; if (a_occ !== 2'd1 || a_out_data !== 8'h33) begin errors++; $display("FAIL bp_third: got occ=%0d d=%h expected 1/33", a_occ, a_out_data); end
        step();
        checks++; if (a_occ !== 2'd0 || a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got occ=%0d v=%b expected 0/0", a_occ, a_out_valid); end
    endtask

    task automatic test_inversion();
        b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_data = 3'b101;
        step();
        checks++; if (b_out_data !== 3'b010 || b_out_valid !== 1'b1) begin errors++; $display("FAIL inv_101: got %b/%b expected 010/1", b_out_data, b_out_valid); end
        b_out_ready = 1'b1; b_in_data = 3'b000;
        step();
        b_in_valid = 1'b0;
        checks++; if (b_out_data !== 3'b111 || b_occ !== 2'd1) begin errors++; $display("FAIL inv_000: got %b occ=%0d expected 111/1", b_out_data, b_occ); end
        step();
        checks++; if (b_occ !== 2'd0) begin errors++; $display("FAIL inv_drain: got occ=%0d expected 0", b_occ); end
    endtask

    task automatic test_flush();
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'h55;
        step();
        a_in_data = 8'h66;
        step();
        checks++; if (a_occ !== 2'd2) begin errors++; $display("FAIL flush_setup: got occ=%0d expected 2", a_occ); end
        a_flush = 1'b1; a_in_data = 8'h44;
        step();
        a_flush = 1'b0; a_in_valid = 1'b0;
        checks++; if (a_occ !== 2'd0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL flush_clear: got occ=%0d v=%b rdy=%b expected 0/0/1", a_occ, a_out_valid, a_in_ready); end
        a_in_valid = 1'b1; a_in_data = 8'h77; a_out_ready = 1'b1;
        step();
        a_in_valid = 1'b0;
        checks++; if (a_out_data !== 8'h77 || a_out_valid !== 1'b1) begin errors++; $display("FAIL flush_next: got %h/%b expected 77/1", a_out_data, a_out_valid); end
        step();
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL flush_drain: got occ=%0d expected 0", a_occ); end
    endtask

    task automatic test_async_reset();
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'h9C;
        step();
        a_in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_out_data !== 8'h00 || a_in_ready !== 1'b1) begin errors++; $display("FAIL async_reset: got v=%b occ=%0d d=%h rdy=%b expected 0/0/00/1", a_out_valid, a_occ, a_out_data, a_in_ready); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_after: got %b expected 0", a_out_valid); end
    endtask

`ifdef TRI_SKID_PARITY_EN
    task automatic test_parity();
        checks++; if (a_par_err !== 1'b0) begin errors++; $display("FAIL par_clean: got %b expected 0", a_par_err); end
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 8'h3C;
        step();
        a_in_valid = 1'b0;
        force dut8.r_main_d = 8'h3D;
        step();
        release dut8.r_main_d;
        checks++; if (a_par_err !== 1'b1) begin errors++; $display("FAIL par_set: got %b expected 1", a_par_err); end
        a_flush = 1'b1;
        step();
        a_flush = 1'b0;
        step();
        checks++; if (a_par_err !== 1'b1) begin errors++; $display("FAIL par_sticky: got %b expected 1", a_par_err); end
        rst_n = 1'b0;
        #1;
        checks++; if (a_par_err !== 1'b0) begin errors++; $display("FAIL par_reset: got %b expected 0", a_par_err); end
        step();
        rst_n = 1'b1;
        step();
    endtask
`endif

    initial begin
        a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 3'b000; b_out_ready = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_inversion();
        test_flush();
        test_async_reset();
`ifdef TRI_SKID_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
